ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-select stage of the 32-bit MIPS pipeline, sitting directly upstream of the ALU. It captures decoded instructions from ID and produces the ALU's `alu_control`, `A` and `B` inputs. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and flags load-use hazards so the pipeline controller can stall. It also carries the MEM/WB control bits and the store data down to the EX/MEM register.

---
 rtl/ex_operand_stage.sv | 141 ++++++++++++++
 tb/tb_ex_operand_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and ALU operand-select stage for the 32-bit MIPS core.
// Captures decoded ID fields, decodes ALU control, forwards operands and detects load-use hazards.
module ex_operand_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              stall,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [4:0]        memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [4:0]        ex_write_reg,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              illegal_op,
  output logic              load_use_stall
);

  typedef struct packed {
    logic              valid;
    logic [3:0]        alu_ctrl;
    logic              illegal;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic [4:0]        wreg;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d;
  logic [3:0] dec_ctrl;
  logic       dec_illegal;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  always_comb begin
    dec_ctrl    = 4'b0010;
    dec_illegal = 1'b0;
    case (id_alu_op)
      2'b00: dec_ctrl = 4'b0010;
      2'b01: dec_ctrl = 4'b0110;
      2'b11: dec_ctrl = 4'b0111;
      default: begin
        case (id_funct)
          6'b100000: dec_ctrl = 4'b0010;
          6'b100010: dec_ctrl = 4'b0110;
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b101010: dec_ctrl = 4'b0111;
          default: begin
            dec_ctrl    = 4'b0010;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Flush beats stall; an invalid ID slot still carries data but no side-effecting controls.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d.valid      = id_valid;
      ex_d.alu_ctrl   = dec_ctrl;
      ex_d.illegal    = id_valid & dec_illegal;
      ex_d.alu_src    = id_valid & id_alu_src;
      ex_d.reg_write  = id_valid & id_reg_write;
      ex_d.mem_read   = id_valid & id_mem_read;
      ex_d.mem_write  = id_valid & id_mem_write;
      ex_d.mem_to_reg = id_valid & id_mem_to_reg;
      ex_d.wreg       = id_reg_dst ? id_rd : id_rt;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.rs_data    = id_rs_data;
      ex_d.rt_data    = id_rt_data;
      ex_d.imm        = id_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
  assign fwd_rs = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == ex_q.rs) ? exmem_result :
                  (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == ex_q.rs) ? memwb_result :
                  ex_q.rs_data;
  assign fwd_rt = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == ex_q.rt) ? exmem_result :
                  (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == ex_q.rt) ? memwb_result :
                  ex_q.rt_data;

  assign alu_control   = ex_q.alu_ctrl;
  assign alu_a         = fwd_rs;
  assign alu_b         = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_write_reg  = ex_q.wreg;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign illegal_op    = ex_q.illegal;

  assign load_use_stall = ex_q.valid & ex_q.mem_read & (ex_q.wreg != 5'd0) & id_valid &
                          ((ex_q.wreg == id_rs) | (ex_q.wreg == id_rt));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: a driver pushes model predictions each cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ex_operand_stage;

  typedef struct packed {
    logic        rstN;
    logic        idValid;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  aluOp;
    logic [5:0]  funct;
    logic        aluSrc;
    logic        regDst;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic        stall;
    logic        flush;
    logic        exRw;
    logic [4:0]  exRd;
    logic [31:0] exRes;
    logic        wbRw;
    logic [4:0]  wbRd;
    logic [31:0] wbRes;
  } stim_t;

  // What the EX slot holds, in instruction terms; known=0 marks an invalid capture
  // whose ALU opcode and immediate select carry no meaning.
  typedef struct packed {
    logic        known;
    logic        valid;
    logic [3:0]  aluCtl;
    logic        illegal;
    logic        aluSrc;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic [4:0]  wreg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
  } slot_t;

  typedef struct packed {
    logic        full;
    logic [3:0]  aluCtl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] store;
    logic [4:0]  wreg;
    logic        valid;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        illegal;
    logic        lus;
  } expect_t;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic stall, flush;
  logic exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [3:0]  alu_control;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0]  ex_write_reg;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, illegal_op, load_use_stall;

  int errors = 0;
  int checks = 0;
  expect_t sb[$];
  stim_t   cur;
  slot_t   st;
  logic [3:0] rMap [logic [5:0]];
  logic [5:0] legalFunct [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  ex_operand_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .illegal_op(illegal_op), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s = '0;
    s.rstN = 1'b1;
    return s;
  endfunction

  function automatic slot_t nextSlot(slot_t old, stim_t s);
    slot_t n = old;
    if (!s.rstN || s.flush) begin
      n = '0;
      n.known = 1'b1;
    end else if (!s.stall) begin
      n = '0;
      n.known  = s.idValid;
      n.valid  = s.idValid;
      n.illegal = 1'b0;
      if (s.aluOp == 2'b00)      n.aluCtl = 4'b0010;
      else if (s.aluOp == 2'b01) n.aluCtl = 4'b0110;
      else if (s.aluOp == 2'b11) n.aluCtl = 4'b0111;
      else if (rMap.exists(s.funct)) n.aluCtl = rMap[s.funct];
      else begin
        n.aluCtl  = 4'b0010;
        n.illegal = s.idValid;
      end
      n.aluSrc   = s.aluSrc & s.idValid;
      n.regWrite = s.regWrite & s.idValid;
      n.memRead  = s.memRead & s.idValid;
      n.memWrite = s.memWrite & s.idValid;
      n.memToReg = s.memToReg & s.idValid;
      n.wreg     = s.regDst ? s.rd : s.rt;
      n.rs = s.rs;
      n.rt = s.rt;
      n.rsData = s.rsData;
      n.rtData = s.rtData;
      n.imm    = s.imm;
    end
    return n;
  endfunction

  function automatic logic [31:0] operand(logic [4:0] r, logic [31:0] regVal, stim_t s);
    if (r == 5'd0) return regVal;
    if (s.exRw && s.exRd == r) return s.exRes;
    if (s.wbRw && s.wbRd == r) return s.wbRes;
    return regVal;
  endfunction

  function automatic expect_t predict(slot_t sl, stim_t s);
    expect_t e;
    e.full    = sl.known;
    e.aluCtl  = sl.aluCtl;
    e.a       = operand(sl.rs, sl.rsData, s);
    e.store   = operand(sl.rt, sl.rtData, s);
    e.b       = sl.aluSrc ? sl.imm : e.store;
    e.wreg    = sl.wreg;
    e.valid   = sl.valid;
    e.rw      = sl.regWrite;
    e.mr      = sl.memRead;
    e.mw      = sl.memWrite;
    e.m2r     = sl.memToReg;
    e.illegal = sl.illegal;
    e.lus     = sl.valid && sl.memRead && sl.wreg != 5'd0 && s.idValid &&
                (sl.wreg == s.rs || sl.wreg == s.rt);
    return e;
  endfunction

  task automatic applyStimulus(input stim_t s);
    id_valid = s.idValid;     id_rs_data = s.rsData;   id_rt_data = s.rtData;
    id_imm = s.imm;           id_rs = s.rs;            id_rt = s.rt;       id_rd = s.rd;
    id_alu_op = s.aluOp;      id_funct = s.funct;      id_alu_src = s.aluSrc;
    id_reg_dst = s.regDst;    id_reg_write = s.regWrite;
    id_mem_read = s.memRead;  id_mem_write = s.memWrite; id_mem_to_reg = s.memToReg;
    stall = s.stall;          flush = s.flush;
    exmem_reg_write = s.exRw; exmem_rd = s.exRd;       exmem_result = s.exRes;
    memwb_reg_write = s.wbRw; memwb_rd = s.wbRd;       memwb_result = s.wbRes;
  endtask

  // One cycle: advance the model over the edge just taken, drive the new inputs,
  // drop reset mid-cycle when requested, then queue the prediction for this cycle.
  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    st = nextSlot(st, cur);
    applyStimulus(s);
    cur = s;
    if (s.rstN) begin
      rst_n = 1'b1;
    end else begin
      #2;
      rst_n = 1'b0;
      st = '0;
      st.known = 1'b1;
    end
    sb.push_back(predict(st, s));
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    checkField("alu_a", alu_a, e.a);
    checkField("ex_store_data", ex_store_data, e.store);
    checkField("ex_write_reg", {27'd0, ex_write_reg}, {27'd0, e.wreg});
    checkField("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
    checkField("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
    checkField("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, e.mr});
    checkField("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, e.mw});
    checkField("ex_mem_to_reg", {31'd0, ex_mem_to_reg}, {31'd0, e.m2r});
    checkField("load_use_stall", {31'd0, load_use_stall}, {31'd0, e.lus});
    if (e.full) begin
      checkField("alu_control", {28'd0, alu_control}, {28'd0, e.aluCtl});
      checkField("illegal_op", {31'd0, illegal_op}, {31'd0, e.illegal});
      checkField("alu_b", alu_b, e.b);
    end
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  function automatic stim_t randomStim();
    stim_t s;
    s.rstN     = ($urandom_range(0, 79) != 0);
    s.idValid  = ($urandom_range(0, 3) != 0);
    s.rsData   = $urandom;
    s.rtData   = $urandom;
    s.imm      = $urandom;
    s.rs       = 5'($urandom_range(0, 7));
    s.rt       = 5'($urandom_range(0, 7));
    s.rd       = 5'($urandom_range(0, 7));
    s.aluOp    = 2'($urandom_range(0, 3));
    s.funct    = ($urandom_range(0, 2) != 0) ? legalFunct[$urandom_range(0, 4)] : 6'($urandom);
    s.aluSrc   = 1'($urandom);
    s.regDst   = 1'($urandom);
    s.regWrite = 1'($urandom);
    s.memRead  = 1'($urandom);
    s.memWrite = 1'($urandom);
    s.memToReg = 1'($urandom);
    s.stall    = ($urandom_range(0, 5) == 0);
    s.flush    = ($urandom_range(0, 9) == 0);
    s.exRw     = 1'($urandom);
    s.exRd     = 5'($urandom_range(0, 7));
    s.exRes    = $urandom;
    s.wbRw     = 1'($urandom);
    s.wbRd     = 5'($urandom_range(0, 7));
    s.wbRes    = $urandom;
    return s;
  endfunction

  initial begin : driver
    stim_t s;
    rMap[6'b100000] = 4'b0010;
    rMap[6'b100010] = 4'b0110;
    rMap[6'b100100] = 4'b0000;
    rMap[6'b100101] = 4'b0001;
    rMap[6'b101010] = 4'b0111;
    cur = idle();
    cur.rstN = 1'b0;
    st = '0;
    st.known = 1'b1;
    rst_n = 1'b0;
    applyStimulus(cur);

    s = idle(); s.rstN = 1'b0;
    step(s);
    step(s);
    step(idle());

    // add $3 = $1 + $2 with 5 and 7, no forwarding
    s = idle(); s.idValid = 1; s.aluOp = 2'b10; s.funct = 6'b100000;
    s.rsData = 5; s.rtData = 7; s.rs = 1; s.rt = 2; s.rd = 3; s.regDst = 1; s.regWrite = 1;
    step(s);
    step(idle());

    // rs=3 matched by both forwarding sources, then rs=0 matched by rd=0
    s = idle(); s.idValid = 1; s.aluOp = 2'b10; s.funct = 6'b100010;
    s.rs = 3; s.rsData = 32'h1111; s.rt = 5; s.rtData = 32'h2222; s.rd = 6; s.regDst = 1; s.regWrite = 1;
    step(s);
    s = idle(); s.exRw = 1; s.exRd = 3; s.exRes = 32'hAAAA; s.wbRw = 1; s.wbRd = 3; s.wbRes = 32'hBBBB;
    step(s);
    s = idle(); s.idValid = 1; s.aluOp = 2'b10; s.funct = 6'b100000;
    s.rs = 0; s.rsData = 32'h1234; s.rt = 0; s.rtData = 32'h5678; s.rd = 7; s.regDst = 1;
    step(s);
    s = idle(); s.exRw = 1; s.exRd = 0; s.exRes = 32'hAAAA; s.wbRw = 1; s.wbRd = 0; s.wbRes = 32'hBBBB;
    step(s);

    // lw $4, followed by a consumer of $4 answered with stall+flush
    s = idle(); s.idValid = 1; s.aluOp = 2'b00; s.aluSrc = 1; s.rs = 2; s.rt = 4; s.imm = 32'h10;
    s.regWrite = 1; s.memRead = 1; s.memToReg = 1;
    step(s);
    s = idle(); s.idValid = 1; s.rs = 9; s.rt = 4; s.aluOp = 2'b10; s.funct = 6'b100101;
    s.stall = 1; s.flush = 1;
    step(s);
    step(idle());

    // beq-class sub held for two stall cycles while ID changes, then stall+flush
    s = idle(); s.idValid = 1; s.aluOp = 2'b01; s.rs = 5; s.rt = 6; s.rsData = 32'hCAFE; s.rtData = 32'hBEEF;
    step(s);
    s = idle(); s.idValid = 1; s.stall = 1; s.aluOp = 2'b11; s.rs = 1; s.rsData = 32'h99; s.regWrite = 1;
    step(s);
    step(s);
    s.flush = 1;
    step(s);
    step(idle());

    // unknown R-type funct
    s = idle(); s.idValid = 1; s.aluOp = 2'b10; s.funct = 6'b000111; s.rs = 1; s.rt = 2; s.rd = 8;
    s.regDst = 1; s.regWrite = 1; s.rsData = 32'h3; s.rtData = 32'h4;
    step(s);
    step(idle());

    for (int i = 0; i < 600; i++) step(randomStim());
    step(idle());

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
